// File: rtl/r2_otf_convert_pkg.sv
// rtl/r2_otf_convert_pkg.sv - shared digit encodings, state type and sizing helper for the radix-2 on-the-fly converter
package r2_otf_convert_pkg;

    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_NEG  = 2'b11;
    localparam logic [1:0] DIG_ILL  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The counter must hold every accepted-digit count up to DELTA+WIDTH.
    function automatic int cnt_width(input int delta, input int width);
        return $clog2(delta + width + 1);
    endfunction

endpackage

// File: rtl/r2_otf_step.sv
// rtl/r2_otf_step.sv - one combinational on-the-fly conversion step for Q/QM
module r2_otf_step
    import r2_otf_convert_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_nxt,
    output logic [W-1:0] qm_nxt
);

    // Append the digit to Q and QM; the illegal code falls through to the zero case.
    always_comb begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
        case (digit)
            DIG_POS: begin
                q_nxt  = {q[W-2:0], 1'b1};
                qm_nxt = {q[W-2:0], 1'b0};
            end
            DIG_NEG: begin
                q_nxt  = {qm[W-2:0], 1'b1};
                qm_nxt = {qm[W-2:0], 1'b0};
            end
            default: begin
                q_nxt  = {q[W-2:0], 1'b0};
                qm_nxt = {qm[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/r2_otf_convert.sv
// rtl/r2_otf_convert.sv - converts an online signed-digit stream to a two's-complement result
module r2_otf_convert
    import r2_otf_convert_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DELTA = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [1:0]       in_digit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_value,
    output logic             err
);

    localparam int CW          = cnt_width(DELTA, WIDTH);
    localparam int SKIP_LAST_I = (DELTA > 0) ? DELTA - 1 : 0;
    localparam int CONV_LAST_I = DELTA + WIDTH - 1;
    localparam logic [CW-1:0] SKIP_LAST = CW'(SKIP_LAST_I);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_LAST_I);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] q;
    logic [WIDTH:0] qm;
    logic [WIDTH:0] q_nxt;
    logic [WIDTH:0] qm_nxt;
    logic          accept;

    assign accept    = in_valid & in_ready;
    assign out_value = q;

    r2_otf_step #(
        .W (WIDTH + 1)
    ) u_step (
        .q      (q),
        .qm     (qm),
        .digit  (in_digit),
        .q_nxt  (q_nxt),
        .qm_nxt (qm_nxt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leading digits are skipped, then WIDTH digits are converted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (DELTA == 0) ? S_CONV : S_SKIP;
            S_SKIP: if (accept && cnt == SKIP_LAST) state_nxt = S_CONV;
            S_CONV: if (accept && cnt == CONV_LAST) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_SKIP:  in_ready  = 1'b1;
            S_CONV:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Digit counter, Q/QM accumulators and sticky error; stalls leave everything untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            q   <= '0;
            qm  <= '1;
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            cnt <= '0;
            q   <= '0;
            qm  <= '1;
            err <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (in_digit == DIG_ILL) begin
                err <= 1'b1;
            end
            if (state == S_CONV) begin
                q  <= q_nxt;
                qm <= qm_nxt;
            end
        end
    end

endmodule
